// File: rtl/iopad_config_loader.sv
// iopad_config_loader
// Sequences bl/wl writes into the per-pad GPIO_SRAM_mem direction cells of an
// IO tile column. One configuration bit is fetched over a valid/ready
// handshake per cell, then written with a SETUP / PULSE / HOLD sequence in
// ascending pad order. All outputs come straight from flops.
//
// Optional feature: define IOPAD_CONFIG_SHADOW_EN to build a shadow register
// of the programmed bits on cfg_shadow; otherwise cfg_shadow is tied to 0.
module iopad_config_loader #(
  parameter int NUM_IO    = 8,
  parameter int ADDR_W    = 3,
  parameter int WL_CYCLES = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic              cfg_data,
  output logic              cfg_ready,
  output logic [NUM_IO-1:0] bl,
  output logic [NUM_IO-1:0] wl,
  output logic              busy,
  output logic              done,
  output logic [NUM_IO-1:0] cfg_shadow
);

  localparam int CNT_W = (WL_CYCLES > 1) ? $clog2(WL_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                bit_q, bit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [NUM_IO-1:0]   bl_q, bl_d;
  logic [NUM_IO-1:0]   wl_q, wl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic: abort has priority over everything outside IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          addr_d  = {ADDR_W{1'b0}};
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cfg_valid && cfg_ready_q) begin
          bit_d   = cfg_data;
          state_d = S_SETUP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WL_CYCLES - 1)) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (addr_q == ADDR_W'(NUM_IO - 1)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    cfg_ready_d = (state_d == S_FETCH);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    bl_d        = {NUM_IO{1'b0}};
    wl_d        = {NUM_IO{1'b0}};
    case (state_d)
      S_SETUP, S_HOLD: begin
        bl_d[addr_d] = bit_d;
      end
      S_PULSE: begin
        bl_d[addr_d] = bit_d;
        wl_d[addr_d] = 1'b1;
      end
      default: begin
        bl_d = {NUM_IO{1'b0}};
        wl_d = {NUM_IO{1'b0}};
      end
    endcase
  end

  // State, datapath and output registers; reset drops wl immediately.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      bit_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      cfg_ready_q <= 1'b0;
      bl_q        <= {NUM_IO{1'b0}};
      wl_q        <= {NUM_IO{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      cfg_ready_q <= cfg_ready_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef IOPAD_CONFIG_SHADOW_EN
  logic [NUM_IO-1:0] shadow_q;

  // Record each completed write at the end of its HOLD cycle.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shadow_q <= {NUM_IO{1'b0}};
    end else if (state_q == S_HOLD && !abort) begin
      shadow_q[addr_q] <= bit_q;
    end else begin
      shadow_q <= shadow_q;
    end
  end

  assign cfg_shadow = shadow_q;
`else
  assign cfg_shadow = {NUM_IO{1'b0}};
`endif

endmodule

// File: tb/tb_iopad_config_loader.sv
// Bench for iopad_config_loader (NUM_IO=4, WL_CYCLES=2). Expected per-cycle
// output records are built from the write timing and queued before each run;
// observed records are queued while the run executes and compared in order.
module tb_iopad_config_loader;
  localparam int N  = 4;
  localparam int WL = 2;

  logic         prog_clk = 1'b0;
  logic         pReset;
  logic         start;
  logic         abort;
  logic         cfg_valid;
  logic         cfg_data;
  logic         cfg_ready;
  logic [N-1:0] bl;
  logic [N-1:0] wl;
  logic         busy;
  logic         done;
  logic [N-1:0] cfg_shadow;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [N-1:0] wl;
    logic [N-1:0] bl;
    logic         busy;
    logic         done;
    logic         rdy;
  } rec_t;

  rec_t sb[$];
  rec_t obs[$];

  iopad_config_loader #(.NUM_IO(N), .ADDR_W(2), .WL_CYCLES(WL)) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .start      (start),
    .abort      (abort),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .bl         (bl),
    .wl         (wl),
    .busy       (busy),
    .done       (done),
    .cfg_shadow (cfg_shadow)
  );

  always #5 prog_clk = ~prog_clk;

  function automatic logic [N-1:0] exp_shadow(input logic [N-1:0] v);
`ifdef IOPAD_CONFIG_SHADOW_EN
    return v;
`else
    return {N{1'b0}};
`endif
  endfunction

  // Expected trace: cycle 1 is the first cycle after the edge sampling start.
  task automatic build_trace(input logic [N-1:0] bits, input int stall_pad,
                             input int stall_len, input int abort_cyc, input int tail);
    rec_t tr [0:63];
    int f, s, last;
    for (int c = 0; c < 64; c++) tr[c] = '0;
    f = 1;
    for (int i = 0; i < N; i++) begin
      s = f + 1 + ((i == stall_pad) ? stall_len : 0);
      for (int c = f; c < s; c++) tr[c].rdy = 1'b1;
      for (int c = s; c <= s + WL + 1; c++) tr[c].bl[i] = bits[i];
      for (int c = s + 1; c <= s + WL; c++) tr[c].wl[i] = 1'b1;
      f = s + WL + 2;
    end
    tr[f].done = 1'b1;
    for (int c = 1; c <= f; c++) tr[c].busy = 1'b1;
    if (abort_cyc > 0) begin
      for (int c = abort_cyc + 1; c < 64; c++) tr[c] = '0;
      last = abort_cyc + tail;
    end else begin
      last = f + tail;
    end
    for (int c = 1; c <= last; c++) sb.push_back(tr[c]);
  endtask

  // Drive one load: start at cycle 0, stream bits with optional stall,
  // optional abort / extra start; record outputs each cycle at negedge.
  task automatic run(input logic [N-1:0] bits, input int stall_pad, input int stall_len,
                     input int abort_cyc, input int start2_cyc, input int ncyc);
    int i, stall_left;
    bit stall_used, hs;
    i = 0; stall_left = 0; stall_used = 1'b0; hs = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge prog_clk); #1;
      start = (cyc == start2_cyc);
      abort = (cyc == abort_cyc);
      if (hs) i++;
      if (cfg_ready && i == stall_pad && !stall_used) begin
        stall_left = stall_len;
        stall_used = 1'b1;
      end
      if (cfg_ready && stall_left > 0) begin
        cfg_valid = 1'b0;
        stall_left--;
      end else begin
        cfg_valid = (i < N);
        cfg_data  = (i < N) ? bits[i[1:0]] : 1'b0;
      end
      @(negedge prog_clk);
      obs.push_back({wl, bl, busy, done, cfg_ready});
      hs = cfg_valid && cfg_ready;
    end
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge prog_clk);
      n_total++;
      if ({cfg_ready, bl, wl, busy, done, cfg_shadow} !== '0)
        $display("FAIL reset cyc %0d: got rdy=%b bl=%b wl=%b busy=%b done=%b sh=%b, want all 0",
                 c, cfg_ready, bl, wl, busy, done, cfg_shadow);
      else n_pass++;
    end
  endtask

  task automatic test_stream();
    logic [N-1:0] bits_t [3];
    int spad [3];
    int slen [3];
    rec_t e, o;
    int cyc;
    bits_t[0] = 4'b1101; spad[0] = -1; slen[0] = 0;
    bits_t[1] = 4'b1101; spad[1] = 2;  slen[1] = 3;
    bits_t[2] = 4'b0110; spad[2] = 0;  slen[2] = 2;
    for (int k = 0; k < 3; k++) begin
      build_trace(bits_t[k], spad[k], slen[k], -1, 2);
      run(bits_t[k], spad[k], slen[k], -1, -1, sb.size());
      cyc = 1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = (obs.size() > 0) ? obs.pop_front() : 'x;
        n_total++;
        if (o !== e)
          $display("FAIL stream%0d cyc %0d: got wl=%b bl=%b busy=%b done=%b rdy=%b, want wl=%b bl=%b busy=%b done=%b rdy=%b",
                   k, cyc, o.wl, o.bl, o.busy, o.done, o.rdy, e.wl, e.bl, e.busy, e.done, e.rdy);
        else n_pass++;
        n_total++;
        if (o.wl != '0 && (o.bl & ~o.wl) != '0)
          $display("FAIL overlap%0d cyc %0d: got wl=%b bl=%b, want bl only on wl pad", k, cyc, o.wl, o.bl);
        else n_pass++;
        cyc++;
      end
      n_total++;
      if (cfg_shadow !== exp_shadow(bits_t[k]))
        $display("FAIL shadow%0d: got %b, want %b", k, cfg_shadow, exp_shadow(bits_t[k]));
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    rec_t e, o;
    int cyc;
    build_trace(4'b1011, -1, 0, -1, 2);
    run(4'b1011, -1, 0, -1, 7, sb.size());
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 'x;
      n_total++;
      if (o !== e)
        $display("FAIL start_busy cyc %0d: got wl=%b bl=%b busy=%b done=%b rdy=%b, want wl=%b bl=%b busy=%b done=%b rdy=%b",
                 cyc, o.wl, o.bl, o.busy, o.done, o.rdy, e.wl, e.bl, e.busy, e.done, e.rdy);
      else n_pass++;
      cyc++;
    end
    @(posedge prog_clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge prog_clk);
      n_total++;
      if ({busy, cfg_ready, wl} !== '0)
        $display("FAIL start_abort_idle cyc %0d: got busy=%b rdy=%b wl=%b, want 0", c, busy, cfg_ready, wl);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    rec_t e, o;
    int cyc;
    @(posedge prog_clk); #1 pReset = 1'b1;
    @(posedge prog_clk); #1 pReset = 1'b0;
    build_trace(4'b1101, -1, 0, 8, 3);
    run(4'b1101, -1, 0, 8, -1, sb.size());
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 'x;
      n_total++;
      if (o !== e)
        $display("FAIL abort cyc %0d: got wl=%b bl=%b busy=%b done=%b rdy=%b, want wl=%b bl=%b busy=%b done=%b rdy=%b",
                 cyc, o.wl, o.bl, o.busy, o.done, o.rdy, e.wl, e.bl, e.busy, e.done, e.rdy);
      else n_pass++;
      cyc++;
    end
    n_total++;
    if (cfg_shadow !== exp_shadow(4'b0001))
      $display("FAIL abort_shadow: got %b, want %b", cfg_shadow, exp_shadow(4'b0001));
    else n_pass++;
    build_trace(4'b0110, -1, 0, -1, 2);
    run(4'b0110, -1, 0, -1, -1, sb.size());
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 'x;
      n_total++;
      if (o !== e)
        $display("FAIL restart cyc %0d: got wl=%b bl=%b busy=%b done=%b rdy=%b, want wl=%b bl=%b busy=%b done=%b rdy=%b",
                 cyc, o.wl, o.bl, o.busy, o.done, o.rdy, e.wl, e.bl, e.busy, e.done, e.rdy);
      else n_pass++;
      cyc++;
    end
    n_total++;
    if (cfg_shadow !== exp_shadow(4'b0110))
      $display("FAIL restart_shadow: got %b, want %b", cfg_shadow, exp_shadow(4'b0110));
    else n_pass++;
  endtask

  task automatic test_preset_mid();
    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0; cfg_valid = 1'b1; cfg_data = 1'b1;
    @(posedge prog_clk); #1;
    cfg_valid = 1'b0;
    @(posedge prog_clk); #1;
    n_total++;
    if (wl !== 4'b0001 || bl !== 4'b0001)
      $display("FAIL preset_pre: got wl=%b bl=%b, want wl=0001 bl=0001", wl, bl);
    else n_pass++;
    #2 pReset = 1'b1;
    #1;
    n_total++;
    if ({wl, bl, busy, cfg_ready, done, cfg_shadow} !== '0)
      $display("FAIL preset_async: got wl=%b bl=%b busy=%b rdy=%b done=%b sh=%b, want all 0",
               wl, bl, busy, cfg_ready, done, cfg_shadow);
    else n_pass++;
    @(posedge prog_clk); #1 pReset = 1'b0;
  endtask

  initial begin
    pReset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    test_reset();
    test_stream();
    test_start_ignored();
    test_abort();
    test_preset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iopad_config_loader.md
Name: iopad_config_loader

Overview:
- Programming-side controller that sequences bl/wl writes into the per-pad GPIO_SRAM_mem direction cells of an IO tile column.
- Accepts a serial stream of configuration bits over a valid/ready handshake.
- Writes one SRAM cell per bit in ascending pad order and reports busy/done.
- Sits between the fabric configuration-protocol front end and NUM_IO logical_tile_io iopad instances.

Parameters:
- NUM_IO, 8, number of iopad SRAM cells driven (>=2).
- ADDR_W, 3, pad address width; must equal clog2(NUM_IO).
- WL_CYCLES, 2, prog_clk cycles wl is held high per write (>=1).

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to program all NUM_IO cells; sampled only in IDLE.
- abort  input  1  synchronous cancel of an in-progress load.
- cfg_valid  input  1  cfg_data valid.
- cfg_data  input  1  next configuration bit (pad order 0..NUM_IO-1).
- cfg_ready  output  1  loader can accept cfg_data this cycle.
- bl  output  NUM_IO  per-cell bit line; only the addressed bit may be nonzero.
- wl  output  NUM_IO  per-cell word line; one-hot or zero.
- busy  output  1  high from the cycle after start until return to IDLE.
- done  output  1  one-cycle pulse after the last cell's write completes.
- cfg_shadow  output  NUM_IO  shadow copy of programmed bits (optional feature).

Behaviour:
- All outputs are registered.
- Reset values: cfg_ready=0, bl=0, wl=0, busy=0, done=0, cfg_shadow=0, addr=0, state=IDLE.
- States: IDLE, FETCH, SETUP, PULSE, HOLD, DONE.
- IDLE: start=1 -> addr=0, go to FETCH. start in any other state is ignored.
- FETCH: cfg_ready=1. On cfg_valid&cfg_ready, latch cfg_data and go to SETUP. cfg_ready drops the next cycle, so at most one bit is accepted per write.
- SETUP (1 cycle): bl[addr]=latched bit, wl=0. Data setup precedes the word line.
- PULSE (WL_CYCLES cycles, internal counter): wl[addr]=1, bl held.
- HOLD (1 cycle): wl=0, bl still held.
- After HOLD: if addr==NUM_IO-1 go to DONE; else addr+1 and go to FETCH.
- bl clears to 0 on entry to FETCH or DONE.
- Per-bit cost: FETCH (>=1 cycle, stretched by cfg_valid low) + 1 + WL_CYCLES + 1.
- DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- busy=1 in FETCH, SETUP, PULSE, HOLD and DONE.
- Address never wraps. No write is issued past NUM_IO-1.
- abort=1 in any non-IDLE state: next cycle state=IDLE, bl=0, wl=0, cfg_ready=0, busy=0, no done pulse.
  - A wl pulse is truncated; that cell's content is undefined.
  - abort has priority over the cfg handshake in the same cycle; the bit is not consumed.
- abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort wins, remain in IDLE.
- pReset mid-operation: immediate return to reset values. wl drops asynchronously.
- cfg_valid while cfg_ready=0 is held off; no data is lost by the loader.

Optional Feature:
- Macro: IOPAD_CONFIG_SHADOW_EN.
- Defined:
  - cfg_shadow[addr] is updated with the latched bit in the HOLD cycle of each completed write.
  - Bits of aborted or unwritten cells keep their previous value.
  - Cleared only by pReset.
- Undefined: no shadow register is built and cfg_shadow is tied to 0.

Test Plan (NUM_IO=4, WL_CYCLES=2):
- Reset release, idle 10 cycles -> all outputs 0, cfg_ready=0, busy=0.
- start at cycle 0, cfg_valid held 1, stream 1,0,1,1:
  - wl[0] high cycles 3-4, wl[1] cycles 8-9, wl[2] cycles 13-14, wl[3] cycles 18-19.
  - bl[0]=1 cycles 2-5, bl[1]=0 throughout.
  - done=1 at cycle 21 only.
  - cfg_shadow=4'b1101 (SHADOW_EN).
- Same stream with cfg_valid low 3 cycles before bit 2 -> wl[2] window shifts +3 cycles, done at cycle 24, bl/wl never both high on different pads.
- abort during PULSE of pad 1 -> wl=0 and busy=0 next cycle, no done, cfg_shadow=4'b0001, a new start restarts at addr 0.
- start asserted while busy -> ignored, sequence and done timing unchanged; start+abort in IDLE -> stays IDLE.
- pReset asserted mid-PULSE (asynchronously between edges) -> wl, bl, busy drop immediately, cfg_shadow=0.
